// File: rtl/mmio_timer_periph_pkg.sv
// Shared constants and types for the MMIO timer peripheral: register offsets,
// TCON bit positions, default window base and the per-register write select.
package mmio_timer_periph_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;
  localparam int          DEFAULT_TICK_W    = 32;

  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_LED     = 3'd3;
  localparam logic [2:0] OFF_DIGI    = 3'd4;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  // One-hot store select produced by the address decoder.
  typedef struct packed {
    logic th;
    logic tl;
    logic tcon;
    logic led;
    logic digi;
  } wr_sel_t;

  // The window is 32 bytes, so only bits [31:5] take part in the match.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:5] == base[31:5];
  endfunction

endpackage

// File: rtl/mmio_timer_periph_if.sv
// Data-side load/store port between the single-cycle CPU and the MMIO peripheral.
interface mmio_timer_periph_if;

  // Strobe semantics: a store happens on every rising clk edge where MemWrite is
  // high and hit is high; a load is MemRead high, and Read_data is valid in the
  // same cycle. There is no backpressure: the peripheral is always ready.
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;
  logic        hit;

  modport master (
    output Address, Write_data, MemRead, MemWrite,
    input  Read_data, hit
  );

  modport slave (
    input  Address, Write_data, MemRead, MemWrite,
    output Read_data, hit
  );

endinterface

// File: rtl/mmio_timer_core.sv
// Reloadable interval timer: TH (reload value), TL (counter) and TCON
// (enable / irq enable / irq status), with CPU writes taking priority.
module mmio_timer_core
  import mmio_timer_periph_pkg::*;
#(
  parameter int TICK_W = DEFAULT_TICK_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              th_we,
  input  logic [TICK_W-1:0] th_wdata,
  input  logic              tl_we,
  input  logic [TICK_W-1:0] tl_wdata,
  input  logic              tcon_we,
  input  logic [2:0]        tcon_wdata,
  output logic [TICK_W-1:0] th,
  output logic [TICK_W-1:0] tl,
  output logic [2:0]        tcon
);

  logic overflow;

  assign overflow = tcon[TCON_EN] && (tl == '1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      // A TH store in a reload cycle only affects the following reload,
      // because TL samples the pre-edge TH value.
      if (th_we) th <= th_wdata;

      if (tl_we) begin
        tl <= tl_wdata;
      end else if (tcon[TCON_EN]) begin
        tl <= overflow ? th : tl + TICK_W'(1);
      end

      // A TCON store in an overflow cycle must not swallow the new interrupt
      // if the stored value keeps interrupts enabled.
      if (tcon_we) begin
        tcon <= {tcon_wdata[TCON_IS] | (overflow & tcon_wdata[TCON_IE]),
                 tcon_wdata[TCON_IE:TCON_EN]};
      end else if (overflow && tcon[TCON_IE]) begin
        tcon[TCON_IS] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_timer_periph.sv
// MMIO peripheral: address decode, combinational read mux, LED/DIGI registers,
// free-running SYSTICK, and the interval timer core.
module mmio_timer_periph
  import mmio_timer_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          TICK_W    = DEFAULT_TICK_W
) (
  input  logic                clk,
  input  logic                reset,
  mmio_timer_periph_if.slave  bus,
  output logic                irq,
  output logic [7:0]          led,
  output logic [11:0]         digi
);

  logic [2:0]        offset;
  logic              addr_lsb_unused;
  wr_sel_t           wr_sel;
  logic [TICK_W-1:0] th;
  logic [TICK_W-1:0] tl;
  logic [2:0]        tcon;
  logic [TICK_W-1:0] systick;
  logic [31:0]       rdata;

  assign bus.hit         = addr_hit(bus.Address, BASE_ADDR);
  assign offset          = bus.Address[4:2];
  assign addr_lsb_unused = ^bus.Address[1:0];

  always_comb begin
    wr_sel = '0;
    if (bus.hit && bus.MemWrite) begin
      case (offset)
        OFF_TH:   wr_sel.th   = 1'b1;
        OFF_TL:   wr_sel.tl   = 1'b1;
        OFF_TCON: wr_sel.tcon = 1'b1;
        OFF_LED:  wr_sel.led  = 1'b1;
        OFF_DIGI: wr_sel.digi = 1'b1;
        default:  wr_sel      = '0;
      endcase
    end
  end

  mmio_timer_core #(
    .TICK_W (TICK_W)
  ) u_core (
    .clk        (clk),
    .reset      (reset),
    .th_we      (wr_sel.th),
    .th_wdata   (TICK_W'(bus.Write_data)),
    .tl_we      (wr_sel.tl),
    .tl_wdata   (TICK_W'(bus.Write_data)),
    .tcon_we    (wr_sel.tcon),
    .tcon_wdata (bus.Write_data[2:0]),
    .th         (th),
    .tl         (tl),
    .tcon       (tcon)
  );

  assign irq = tcon[TCON_IS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led     <= '0;
      digi    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + TICK_W'(1);
      if (wr_sel.led)  led  <= bus.Write_data[7:0];
      if (wr_sel.digi) digi <= bus.Write_data[11:0];
    end
  end

  // Loads see pre-edge register values, so a load+store pair returns old data.
  always_comb begin
    rdata = '0;
    case (offset)
      OFF_TH:      rdata = 32'(th);
      OFF_TL:      rdata = 32'(tl);
      OFF_TCON:    rdata = {29'd0, tcon};
      OFF_LED:     rdata = {24'd0, led};
      OFF_DIGI:    rdata = {20'd0, digi};
      OFF_SYSTICK: rdata = 32'(systick);
      default:     rdata = '0;
    endcase
  end

  assign bus.Read_data = (bus.hit && bus.MemRead) ? rdata : 32'h0;

endmodule

// File: tb/tb_mmio_timer_periph.sv
// Directed bench for mmio_timer_periph: register map, timer reload/irq,
// simultaneous CPU/timer events, decode edges and asynchronous reset.
module tb_mmio_timer_periph;

  localparam logic [31:0] A_TH      = 32'h4000_0000;
  localparam logic [31:0] A_TL      = 32'h4000_0004;
  localparam logic [31:0] A_TCON    = 32'h4000_0008;
  localparam logic [31:0] A_LED     = 32'h4000_000C;
  localparam logic [31:0] A_DIGI    = 32'h4000_0010;
  localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq;
  logic [7:0]  led;
  logic [11:0] digi;

  mmio_timer_periph_if bus ();

  mmio_timer_periph dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq   (irq),
    .led   (led),
    .digi  (digi)
  );

  // ---------------- clock ----------------
  always #10 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called in the low clock phase; the store commits at the next rising edge
  // and the task returns at the following falling edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    bus.Address    = addr;
    bus.Write_data = data;
    bus.MemWrite   = 1'b1;
    @(posedge clk);
    #1 bus.MemWrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus.Address = addr;
    bus.MemRead = 1'b1;
    #1 data = bus.Read_data;
    bus.MemRead = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check_val(tag, d, exp);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] s0, s1, d;
  logic [31:0] zero_addrs [7];
  logic [3:0]  irq_exp;

  initial begin
    zero_addrs = '{A_TH, A_TL, A_TCON, A_LED, A_DIGI, 32'h4000_0018, 32'h4000_001C};
    bus.Address    = '0;
    bus.Write_data = '0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    reset          = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_irq",  32'(irq),  32'h0);
    check_val("rst_led",  32'(led),  32'h0);
    check_val("rst_digi", 32'(digi), 32'h0);
    reset = 1'b1;

    // 1: SYSTICK advances one per cycle, other registers read 0
    @(negedge clk);
    bus_read(A_SYSTICK, s0);
    repeat (10) @(negedge clk);
    bus_read(A_SYSTICK, s1);
    check_val("systick_delta10", s1 - s0, 32'd10);
    foreach (zero_addrs[i]) begin
      @(negedge clk);
      check_reg("zero_after_reset", zero_addrs[i], 32'h0);
    end

    // 2: reload at all-ones, irq rises in the reload cycle
    bus_write(A_TH, 32'hFFFF_FFFC);
    bus_write(A_TL, 32'hFFFF_FFFC);
    check_reg("tl_hold_disabled", A_TL, 32'hFFFF_FFFC);
    bus_write(A_TCON, 32'h3);
    check_reg("tl_first_after_en", A_TL, 32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFD);
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFC);
    irq_exp = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_reg("tl_seq", A_TL, exp_q.pop_front());
      check_val("irq_seq", 32'(irq), 32'(irq_exp[i]));
    end
    repeat (4) @(negedge clk);
    check_reg("tl_period4", A_TL, 32'hFFFF_FFFC);
    check_val("irq_held", 32'(irq), 32'h1);

    // 3: software clear, re-arm, and TCON stores in overflow cycles
    bus_write(A_TCON, 32'h3);
    check_val("irq_cleared", 32'(irq), 32'h0);
    check_reg("tl_after_clear", A_TL, 32'hFFFF_FFFD);
    repeat (2) @(negedge clk);
    check_val("irq_before_ovf", 32'(irq), 32'h0);
    @(negedge clk);
    check_val("irq_rearmed", 32'(irq), 32'h1);
    repeat (3) @(negedge clk);
    check_reg("tl_pre_ovf", A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h1);
    check_reg("tcon_ovf_ie0", A_TCON, 32'h1);
    check_val("irq_ovf_ie0", 32'(irq), 32'h0);
    check_reg("tl_reload_ie0", A_TL, 32'hFFFF_FFFC);
    repeat (3) @(negedge clk);
    bus_write(A_TCON, 32'h3);
    check_reg("tcon_ovf_ie1", A_TCON, 32'h7);
    check_val("irq_ovf_ie1", 32'(irq), 32'h1);

    // CPU store to TL beats the increment
    bus_write(A_TL, 32'h10);
    check_reg("tl_write_wins", A_TL, 32'h10);
    @(negedge clk);
    check_reg("tl_inc_after_write", A_TL, 32'h11);

    // TH store in a reload cycle: TL takes the old TH
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TH, 32'h100);
    check_reg("tl_old_th", A_TL, 32'hFFFF_FFFC);
    check_reg("th_new", A_TH, 32'h100);
    repeat (4) @(negedge clk);
    check_reg("tl_new_th_reload", A_TL, 32'h100);

    // 4: LED and DIGI keep only their low bits
    bus_write(A_LED, 32'hDEAD_BEA5);
    check_val("led_out", 32'(led), 32'hA5);
    check_reg("led_read", A_LED, 32'hA5);
    bus_write(A_DIGI, 32'hFFFF_F3F6);
    check_val("digi_out", 32'(digi), 32'h3F6);
    check_reg("digi_read", A_DIGI, 32'h3F6);

    // Load and store together: load returns the pre-store value
    bus.Address    = A_LED;
    bus.Write_data = 32'h5A;
    bus.MemWrite   = 1'b1;
    bus.MemRead    = 1'b1;
    #1 check_val("rw_old_value", bus.Read_data, 32'hA5);
    @(posedge clk);
    #1 bus.MemWrite = 1'b0;
    bus.MemRead = 1'b0;
    check_val("rw_led_new", 32'(led), 32'h5A);
    @(negedge clk);

    // 5: decode edges
    bus.Address = 32'h1000_0000;
    bus.MemRead = 1'b1;
    #1 check_val("miss_hit", 32'(bus.hit), 32'h0);
    check_val("miss_rdata", bus.Read_data, 32'h0);
    bus.Address = A_TCON;
    bus.MemRead = 1'b0;
    #1 check_val("inwin_hit", 32'(bus.hit), 32'h1);
    check_val("noread_rdata", bus.Read_data, 32'h0);
    @(negedge clk);
    bus_read(A_SYSTICK, s0);
    bus_write(A_SYSTICK, 32'h0);
    bus_read(A_SYSTICK, s1);
    check_val("systick_ro", s1 - s0, 32'd1);
    check_reg("unaligned_tcon", 32'h4000_0009, 32'h7);

    // 6: asynchronous reset mid-count
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reg("arst_tl", A_TL, 32'h0);
    check_reg("arst_tcon", A_TCON, 32'h0);
    check_reg("arst_th", A_TH, 32'h0);
    check_val("arst_irq", 32'(irq), 32'h0);
    check_val("arst_led", 32'(led), 32'h0);
    check_val("arst_digi", 32'(digi), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reg("tl_hold_after_rst", A_TL, 32'h0);
    bus_write(A_TCON, 32'h1);
    check_reg("tl_resume0", A_TL, 32'h0);
    @(negedge clk);
    check_reg("tl_resume1", A_TL, 32'h1);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_timer_periph.md
Name: mmio_timer_periph

Overview:
Memory-mapped peripheral that answers the CPU's data-side load/store port (Address, Write_data, MemRead, MemWrite, Read_data) for a fixed I/O window, alongside the data memory. It holds a reloadable interval timer with interrupt, an LED register, a seven-segment (digi) register and a free-running system tick counter. Reads are combinational, so the single-cycle CPU sees load data in the same cycle; writes commit on the rising clock edge. The CPU selects between this block and data memory using the `hit` output.

Parameters:
BASE_ADDR, 32'h4000_0000, base of the 0x20-byte register window; bits [4:0] must be zero
TICK_W, 32, width of the timer and systick counters

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Address  input  32  byte address from the CPU ALU result
Write_data  input  32  store data, taken from the CPU rt register
MemRead  input  1  load strobe
MemWrite  input  1  store strobe
Read_data  output  32  load data, combinational
hit  output  1  Address lies in the window, combinational
irq  output  1  timer interrupt request, equal to TCON[2]
led  output  8  LED drive
digi  output  12  [11:8] anode select, [7:0] segment pattern

Behaviour:
- Decode:
  - hit = (Address[31:5] == BASE_ADDR[31:5]).
  - Offset = Address[4:2]; Address[1:0] are ignored.
- Register map (offset: name, access, reset value):
  - 0x00: TH, RW, 0
  - 0x04: TL, RW, 0
  - 0x08: TCON, RW, 0. Bit 0 = enable, bit 1 = irq enable, bit 2 = irq status. Bits 31:3 read as 0.
  - 0x0C: LED, RW in bits [7:0], 0
  - 0x10: DIGI, RW in bits [11:0], 0
  - 0x14: SYSTICK, RO, 0. Writes are ignored.
  - 0x18, 0x1C: reserved. Read as 0; writes ignored.
- Reads:
  - Read_data = selected register when hit & MemRead; otherwise 32'h0.
  - No side effects on read, including TCON status.
- Writes: when hit & MemWrite, the register at Offset updates at the next rising clk edge. Unused bits are discarded.
- MemRead and MemWrite both high: the write commits at the edge, and Read_data shows the pre-write value.
- Timer, evaluated every cycle when TCON[0] = 1:
  - If TL == all-ones: TL <= TH (reload). If TCON[1] = 1, TCON[2] <= 1.
  - Otherwise: TL <= TL + 1.
  - When TCON[0] = 0, TL holds.
- Interval: overflow period = (2^TICK_W − TH) cycles after the first reload.
- SYSTICK increments every cycle, wraps to 0 after all-ones, and is never gated.
- Simultaneous events:
  - CPU write to TL in the same cycle as an increment or reload: the CPU write wins.
  - CPU write to TH in a reload cycle: TL loads the old TH; the new TH takes effect at the next reload.
  - CPU write to TCON in an overflow cycle: bits [1:0] take Write_data. Bit 2 = Write_data[2] | (overflow & Write_data[1]), so a pending interrupt is never lost.
  - Software clears the interrupt by writing TCON with bit 2 = 0.
- irq = TCON[2], registered, with no combinational path from the inputs.
- led = LED[7:0]; digi = DIGI[11:0], both registered.
- Reset (reset = 0): all registers are cleared asynchronously. irq, led and digi go to 0 immediately. Counting resumes on the first edge after reset deasserts. Reset mid-count discards timer state.

Decomposition:
- Shared package holds:
  - Offset constants: OFF_TH=3'd0, OFF_TL=3'd1, OFF_TCON=3'd2, OFF_LED=3'd3, OFF_DIGI=3'd4, OFF_SYSTICK=3'd5.
  - TCON bit indices: TCON_EN=0, TCON_IE=1, TCON_IS=2.
  - Default BASE_ADDR.
- One natural sub-module, `mmio_timer_core`. It holds TH/TL/TCON and the reload/interrupt logic, and takes write-enable and data per register.
- Decode, read mux, LED, DIGI and SYSTICK stay in the top block.

Test Plan:
1. Reset, then release. Load 0x40000014 at cycles 1 and 11 → values differ by exactly 10. All other offsets read 0. irq = 0, led = 0, digi = 0.
2. Store TH = 0xFFFFFFFC, TL = 0xFFFFFFFC, then TCON = 0x3 → TL reads 0xFFFFFFFD, 0xFFFFFFFE, 0xFFFFFFFF, then 0xFFFFFFFC. irq rises in the reload cycle, and overflow repeats every 4 cycles.
3. With irq = 1, store TCON = 0x3 → irq drops at the next edge and rises again at the next overflow. Store TCON = 0x1 in an overflow cycle → TCON reads 0x1 and irq stays 0.
4. Store to 0x4000000C with 0xDEADBEA5 → led = 0xA5 and a load returns 0x000000A5. Store to 0x40000010 with 0xFFFFF3F6 → digi = 12'h3F6.
5. Address 0x10000000 with MemRead = 1 → hit = 0 and Read_data = 0. Store to 0x40000014 → SYSTICK keeps counting unchanged. Address 0x40000009 → decodes as TCON.
6. With TL counting, assert reset for 1 cycle mid-count → TL, TCON and irq are 0 asynchronously, before the next edge. TL holds at 0 until TCON is rewritten.
